// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port (data/instr) arbiter onto a single-cycle RAM with starvation-forced instr priority.
module ram_arbiter #(
  parameter int unsigned     MAX_STARVE = 4,
  parameter longint unsigned RAM_BYTES  = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic        i_err,
  output logic [31:0] i_rdata,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  typedef enum logic {DATA_PRI, INSTR_PRI} state_t;
  localparam logic [7:0] MAX_S = 8'(MAX_STARVE);
  state_t state, state_nxt;
  logic [7:0] starve_cnt, starve_nxt;
  logic rsp_valid, rsp_src, rsp_err;
  logic d_in, i_in, d_sel, i_sel;
  assign d_in = 64'(d_addr) < RAM_BYTES;
  assign i_in = 64'(i_addr) < RAM_BYTES;
  always_comb begin
    d_gnt = d_req && (state == DATA_PRI || !i_req);
    i_gnt = i_req && !d_gnt;
    d_sel = d_gnt && d_in;
    i_sel = i_gnt && i_in;
    starve_nxt = (i_req && !i_gnt) ? ((starve_cnt >= MAX_S) ? MAX_S : starve_cnt + 8'd1) : 8'd0;
    state_nxt = (state == DATA_PRI) ? ((i_req && !i_gnt && starve_nxt == MAX_S) ? INSTR_PRI : DATA_PRI)
                                    : ((i_gnt || !i_req) ? DATA_PRI : INSTR_PRI);
    ram_req   = d_sel || i_sel;
    ram_we    = d_sel && d_we;
    ram_addr  = d_sel ? d_addr : i_sel ? i_addr : 32'd0;
    ram_be    = d_sel ? d_be : i_sel ? 4'hF : 4'h0;
    ram_wdata = d_sel ? d_wdata : 32'd0;
  end
  // rsp_src: 0 = data, 1 = instr; out-of-range grants carry err instead of RAM data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DATA_PRI;
      starve_cnt <= 8'd0;
      rsp_valid  <= 1'b0;
      rsp_src    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      rsp_valid  <= d_gnt || i_gnt;
      rsp_src    <= i_gnt;
      rsp_err    <= (d_gnt && !d_in) || (i_gnt && !i_in);
    end
  end
  assign d_rvalid = rsp_valid && !rsp_src;
  assign i_rvalid = rsp_valid && rsp_src;
  assign d_err    = d_rvalid && rsp_err;
  assign i_err    = i_rvalid && rsp_err;
  assign d_rdata  = (d_rvalid && !rsp_err) ? ram_rdata : 32'd0;
  assign i_rdata  = (i_rvalid && !rsp_err) ? ram_rdata : 32'd0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: random + directed scoreboard bench for ram_arbiter against a starvation-run reference model.
module tb_ram_arbiter;
  localparam int unsigned     MAX = 4;
  localparam longint unsigned RB  = 65536;
  logic        clk = 0, rst_n = 0;
  logic        d_req = 0, d_we = 0, i_req = 0;
  logic [31:0] d_addr = 0, d_wdata = 0, i_addr = 0, ram_rdata = 0;
  logic [3:0]  d_be = 0;
  logic        d_gnt, d_rvalid, d_err, i_gnt, i_rvalid, i_err, ram_req, ram_we;
  logic [31:0] d_rdata, i_rdata, ram_addr, ram_wdata;
  logic [3:0]  ram_be;
  ram_arbiter #(.MAX_STARVE(MAX), .RAM_BYTES(RB)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_err(i_err), .i_rdata(i_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  always #5 clk = ~clk;
  typedef struct {int due; logic src; logic err; logic [31:0] rdata;} rsp_t;
  rsp_t q[$];
  int errors = 0, checks = 0, cyc = 0, run = 0;
  logic [31:0] next_rdata = 0;
  logic last_i_gnt, last_d_gnt;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endfunction
  // Monitor: the response due in this cycle, or silence
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      rsp_t e;
      e = q.pop_front();
      chk("d_rvalid", 64'(d_rvalid), 64'(!e.src));
      chk("i_rvalid", 64'(i_rvalid), 64'(e.src));
      chk("d_err", 64'(d_err), 64'(!e.src && e.err));
      chk("i_err", 64'(i_err), 64'(e.src && e.err));
      chk("d_rdata", 64'(d_rdata), e.src ? 64'd0 : 64'(e.rdata));
      chk("i_rdata", 64'(i_rdata), e.src ? 64'(e.rdata) : 64'd0);
    end else
      chk("rsp_idle", 64'({d_rvalid, i_rvalid, d_err, i_err}), 64'd0);
  end
  task automatic step(input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                      input logic [3:0] be, input logic ir, input logic [31:0] ia);
    logic ipri, ed, ei, din, iin, dsel, isel;
    @(posedge clk);
    #1;
    ram_rdata = next_rdata;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; d_be = be; i_req = ir; i_addr = ia;
    #1;
    ipri = rst_n && run == int'(MAX);
    ed = dr && (!ir || !ipri);
    ei = ir && !ed;
    din = 64'(da) < RB;
    iin = 64'(ia) < RB;
    dsel = ed && din;
    isel = ei && iin;
    chk("state", 64'(dut.state), 64'(ipri));
    chk("starve_cnt", 64'(dut.starve_cnt), 64'(rst_n ? run : 0));
    chk("d_gnt", 64'(d_gnt), 64'(ed));
    chk("i_gnt", 64'(i_gnt), 64'(ei));
    chk("ram_req", 64'(ram_req), 64'(dsel || isel));
    if (dsel) begin
      chk("ram_addr_d", 64'(ram_addr), 64'(da));
      chk("ram_we_d", 64'(ram_we), 64'(dw));
      chk("ram_be_d", 64'(ram_be), 64'(be));
      chk("ram_wdata_d", 64'(ram_wdata), 64'(dwd));
    end else if (isel) begin
      chk("ram_addr_i", 64'(ram_addr), 64'(ia));
      chk("ram_we_i", 64'(ram_we), 64'd0);
      chk("ram_be_i", 64'(ram_be), 64'hF);
      chk("ram_wdata_i", 64'(ram_wdata), 64'd0);
    end else if (!ed && !ei)
      chk("ram_idle", {ram_addr, ram_wdata}, 64'd0);
    last_d_gnt = ed;
    last_i_gnt = ei;
    if (rst_n) begin
      run = (ir && !ei) ? ((run + 1 > int'(MAX)) ? int'(MAX) : run + 1) : 0;
      if (ed || ei) begin
        next_rdata = $urandom;
        q.push_back('{cyc + 1, ei, ei ? !iin : !din, (ei ? iin : din) ? next_rdata : 32'd0});
      end
    end else
      run = 0;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    #2;
    chk("rst_rvalid", 64'({d_rvalid, i_rvalid, d_err, i_err}), 64'd0);
    chk("rst_state", 64'(dut.state), 64'd0);
    chk("rst_starve", 64'(dut.starve_cnt), 64'd0);
    idle();
    #1 rst_n = 1;
    idle();
    step(0, 0, 0, 0, 0, 1, 32'h100);
    step(1, 1, 32'h20, 32'hA5A5_1234, 4'b0011, 0, 0);
    step(1, 0, 32'(RB), 0, 4'hF, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'(RB) + 32'd4);
    idle();
    for (int n = 0; n < 15; n++) begin
      step(1, 0, 32'($urandom_range(0, 65535)), 0, 4'hF, 1, 32'($urandom_range(0, 65535)));
      chk("pattern_i", 64'(i_gnt), 64'(n % 5 == 4));
    end
    idle();
    for (int n = 0; n < 16; n++) begin
      step(n % 2 == 0, 0, 32'h40, 0, 4'hF, 1, 32'h80);
      chk("alt_i_gnt", 64'(i_gnt), 64'(n % 2 == 1));
      chk("alt_state", 64'(dut.state), 64'd0);
    end
    for (int n = 0; n < 300; n++) begin
      logic dr, ir;
      logic [31:0] da, ia;
      dr = $urandom_range(0, 3) != 0;
      ir = $urandom_range(0, 3) != 0;
      da = ($urandom_range(0, 7) == 0) ? 32'(RB) + 32'($urandom_range(0, 4096)) : 32'($urandom_range(0, 65535));
      ia = ($urandom_range(0, 7) == 0) ? 32'(RB) + 32'($urandom_range(0, 4096)) : 32'($urandom_range(0, 65535));
      step(dr, 1'($urandom), da, $urandom, 4'($urandom), ir, ia);
    end
    idle();
    step(1, 0, 32'h10, 0, 4'hF, 1, 32'h14);
    #1 rst_n = 0;
    if (last_d_gnt || last_i_gnt) void'(q.pop_back());
    run = 0;
    idle();
    idle();
    rst_n = 1;
    idle();
    idle();
    for (int n = 0; n < 20; n++) step(1'($urandom), 0, 32'($urandom_range(0, 65535)), 0, 4'hF, 1, 32'h200);
    idle();
    idle();
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
